mcwmfifo: RTL and testbench
===========================

# mcwmfifo

Multi-channel watermark FIFO: NCHAN independent FIFO queues share one storage array, with one push port and one pop port, each steered by a channel id. It is the next generation of the single-queue watermark FIFO. Additions are per-channel counts, full/empty flags, high-watermark flags with hysteresis (set/clear thresholds), and an overflow pulse. Pop is qualified internally with the selected channel's empty flag, so the pop port can be driven directly by an arbiter grant. Single clock domain only; it sits between request fan-in and per-channel consumers.

## Interface
- WIDTH, 64, data width in bits
- DEPTH, 16, entries per channel (≥2, any integer)
- NCHAN, 4, number of channels (≥1)
- HIWM, 12, hiwm set threshold: flag sets when count ≥ HIWM
- LOWM, 4, hiwm clear threshold: flag clears when count ≤ LOWM (0 ≤ LOWM < HIWM ≤ DEPTH)
- RAM_STYLE, "distributed", storage inference attribute
- Derived widths: DBIT = f_enc_bits(DEPTH); CBIT = max(1, f_enc_bits(NCHAN))
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- push  in  1  push request
- push_ch  in  CBIT  push channel id
- din  in  WIDTH  push data
- full  out  NCHAN  per-channel full, count == DEPTH
- hiwm  out  NCHAN  per-channel high-watermark flag, with hysteresis
- ovf  out  1  one-cycle pulse: the previous cycle's push was dropped
- cnt  out  NCHAN*(DBIT+1)  per-channel occupancy; channel c occupies bits [c*(DBIT+1) +: DBIT+1]
- pop  in  1  pop request; may stay asserted while the channel is empty
- pop_ch  in  CBIT  pop channel id
- empty  out  NCHAN  per-channel empty, count == 0
- dout  out  WIDTH  registered read data
- dout_vld  out  1  dout holds the data of the previous cycle's accepted pop
- dout_ch  out  CBIT  channel of dout

## Operation
- Storage: one array of NCHAN*DEPTH entries. Channel c, pointer p maps to address c*DEPTH+p.
- Each channel has its own wptr, rptr and count. Pointers increment modulo DEPTH, so DEPTH-1 wraps to 0, including for DEPTH values that are not a power of 2.
- Accepted push: a_push = push & (push_ch < NCHAN) & ~full[push_ch].
  - Writes din at the channel's wptr.
  - Increments that channel's wptr.
- Dropped push: push & ~a_push. ovf is 1 on the next cycle and otherwise 0.
- Accepted pop: a_pop = pop & (pop_ch < NCHAN) & ~empty[pop_ch].
  - A rejected pop has no effect and raises no error.
  - On an accepted pop, the next cycle carries dout = mem[rptr], dout_ch = pop_ch, dout_vld = 1, and that channel's rptr increments.
  - With no accepted pop, dout_vld = 0 and dout/dout_ch hold their values.
- Count update per channel: next = cnt + a_push(c) − a_pop(c).
  - An accepted push and pop on the same channel in the same cycle leave the count unchanged.
- full and empty are decoded from the registered count. They reflect the current registered state only, so:
  - A push to a full channel is dropped even when a pop from that channel is accepted in the same cycle.
  - A pop from an empty channel is rejected even when a push to that channel occurs in the same cycle.
  - Read-during-write to the same entry therefore cannot occur.
- hiwm is registered per channel from the next count:
  - next ≥ HIWM: set to 1.
  - next ≤ LOWM: clear to 0.
  - Otherwise: hold.
- Reset values:
  - All pointers and counts are 0, so cnt = 0.
  - empty = all 1s; full = 0; hiwm = 0; ovf = 0.
  - dout_vld = 0; dout_ch = 0.
  - dout is not reset; its value is a don't-care until the first dout_vld.
- Reset asserted mid-operation: discards all queued data and any in-flight output.
  - The next cycle shows the reset values.
  - Pushes and pops presented during reset are ignored.

## Timing
- Push at cycle n: cnt, empty, full and hiwm change at n+1.
- Pop accepted at cycle n: dout, dout_vld and dout_ch are valid at n+1; cnt and full change at n+1.
- Push-to-data latency: push at n, earliest pop at n+1, data out at n+2.
- Throughput: one push and one pop per cycle, on any channels, including the same channel.
- ovf is a single-cycle pulse at n+1 for each dropped push at n.

## Test plan
- Reset then single push/pop, NCHAN=4, DEPTH=16: push 0xA5 to ch2 at n -> empty[2]=0 and cnt ch2=1 at n+1. Pop ch2 at n+1 -> dout=0xA5, dout_ch=2, dout_vld=1 at n+2; empty[2]=1.
- Fill and overflow: push 16 words to ch1 -> full[1]=1. A 17th push -> ovf=1 for one cycle, cnt ch1 stays 16, other channels unaffected. Draining 16 pops returns the words in order.
- Wrap with DEPTH=12: push and pop 40 words on ch0 with a steady-state depth of 5 -> data in order and no corruption of ch0's neighbour ch1, which holds 3 words and is checked afterwards.
- Hysteresis, HIWM=12, LOWM=4: push 12 words -> hiwm set at the cycle after the 12th push. Pop down to 5 -> hiwm still 1. Pop to 4 -> hiwm clears the next cycle.
- Simultaneous events:
  - Push and pop on the same non-empty channel -> count constant, and dout returns the oldest word.
  - Push and pop on an empty channel -> pop rejected, dout_vld=0, count becomes 1.
  - pop held high for 10 cycles on an empty channel -> no dout_vld and no count change.
- Reset mid-operation: ch0 and ch3 hold 7 words each, and a pop is accepted in the reset cycle -> the next cycle shows cnt=0, empty=all 1s, hiwm=0, dout_vld=0. Subsequent traffic is correct.

Source files
------------

// File: rtl/mcwmfifo.sv
// ============================================================================
// mcwmfifo : multi-channel FIFO on one shared array with per-channel
//            count, full/empty, hysteretic high-watermark and overflow pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module mcwmfifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int NCHAN     = 4,
  parameter int HIWM      = 12,
  parameter int LOWM      = 4,
  parameter     RAM_STYLE = "distributed",
  localparam int DBIT     = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CBIT     = (NCHAN <= 2) ? 1 : $clog2(NCHAN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [CBIT-1:0]             push_ch,
  input  logic [WIDTH-1:0]            din,
  output logic [NCHAN-1:0]            full,
  output logic [NCHAN-1:0]            hiwm,
  output logic                        ovf,
  output logic [NCHAN*(DBIT+1)-1:0]   cnt,
  input  logic                        pop,
  input  logic [CBIT-1:0]             pop_ch,
  output logic [NCHAN-1:0]            empty,
  output logic [WIDTH-1:0]            dout,
  output logic                        dout_vld,
  output logic [CBIT-1:0]             dout_ch
);

  localparam int CW   = DBIT + 1;
  localparam int NENT = NCHAN * DEPTH;
  localparam int ABIT = (NENT <= 2) ? 1 : $clog2(NENT);

  // Pointer wrap is explicit so non-power-of-two depths stay inside their slice.
  function automatic logic [DBIT-1:0] f_inc(input logic [DBIT-1:0] p);
    return (p == DBIT'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] r_mem [NENT];

  logic [WIDTH-1:0]             r_dout;
  logic                         r_dout_vld;
  logic [CBIT-1:0]              r_dout_ch;
  logic                         r_ovf;

  logic [NCHAN-1:0][DBIT-1:0]   w_wptr;
  logic [NCHAN-1:0][DBIT-1:0]   w_rptr;
  logic [NCHAN-1:0]             w_full;
  logic [NCHAN-1:0]             w_empty;
  logic                         w_push_in;
  logic                         w_pop_in;
  logic [CBIT-1:0]              w_pch;
  logic [CBIT-1:0]              w_qch;
  logic                         w_a_push;
  logic                         w_a_pop;
  logic [ABIT-1:0]              w_waddr;
  logic [ABIT-1:0]              w_raddr;

  // Out-of-range ids are folded to channel 0 only to keep the lookups legal;
  // the range flag still vetoes acceptance.
  assign w_push_in = (int'(push_ch) < NCHAN);
  assign w_pop_in  = (int'(pop_ch) < NCHAN);
  assign w_pch     = w_push_in ? push_ch : '0;
  assign w_qch     = w_pop_in  ? pop_ch  : '0;
  assign w_a_push  = push & w_push_in & ~w_full[w_pch];
  assign w_a_pop   = pop  & w_pop_in  & ~w_empty[w_qch];
  assign w_waddr   = ABIT'(int'(w_pch) * DEPTH + int'(w_wptr[w_pch]));
  assign w_raddr   = ABIT'(int'(w_qch) * DEPTH + int'(w_rptr[w_qch]));

  generate
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      logic [CW-1:0]   r_cnt;
      logic [DBIT-1:0] r_wptr;
      logic [DBIT-1:0] r_rptr;
      logic            r_hiwm;
      logic            w_inc;
      logic            w_dec;
      logic [CW-1:0]   w_nxt;

      assign w_inc   = w_a_push && (w_pch == CBIT'(c));
      assign w_dec   = w_a_pop  && (w_qch == CBIT'(c));
      assign w_nxt   = r_cnt + CW'(w_inc) - CW'(w_dec);

      assign w_full[c]          = (r_cnt == CW'(DEPTH));
      assign w_empty[c]         = (r_cnt == '0);
      assign w_wptr[c]          = r_wptr;
      assign w_rptr[c]          = r_rptr;
      assign hiwm[c]            = r_hiwm;
      assign cnt[c*CW +: CW]    = r_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt  <= '0;
          r_wptr <= '0;
          r_rptr <= '0;
          r_hiwm <= 1'b0;
        end else begin
          r_cnt <= w_nxt;
          if (w_inc) r_wptr <= f_inc(r_wptr);
          if (w_dec) r_rptr <= f_inc(r_rptr);
          // Between the thresholds the flag keeps its last value.
          if (w_nxt >= CW'(HIWM))
            r_hiwm <= 1'b1;
          else if (w_nxt <= CW'(LOWM))
            r_hiwm <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_a_push && !reset) r_mem[w_waddr] <= din;
  end

  always_ff @(posedge clk) begin
    if (w_a_pop && !reset) r_dout <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout_vld <= 1'b0;
      r_dout_ch  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_dout_vld <= w_a_pop;
      if (w_a_pop) r_dout_ch <= pop_ch;
      r_ovf      <= push & ~w_a_push;
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign ovf      = r_ovf;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign dout_ch  = r_dout_ch;

endmodule

`default_nettype wire

// File: tb/tb_mcwmfifo.sv
// ============================================================================
// tb_mcwmfifo : two mcwmfifo instances (16x4 and 12x3) driven in lockstep and
//               compared each cycle against a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mcwmfifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [1:0]  push_ch;
  logic [63:0] din;
  logic        pop;
  logic [1:0]  pop_ch;

  logic [3:0]  a_full, a_hiwm, a_empty;
  logic        a_ovf, a_vld;
  logic [19:0] a_cnt;
  logic [63:0] a_dout;
  logic [1:0]  a_ch;

  logic [2:0]  b_full, b_hiwm, b_empty;
  logic        b_ovf, b_vld;
  logic [14:0] b_cnt;
  logic [63:0] b_dout;
  logic [1:0]  b_ch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcwmfifo u_a (
    .clk(clk), .reset(reset), .push(push), .push_ch(push_ch), .din(din),
    .full(a_full), .hiwm(a_hiwm), .ovf(a_ovf), .cnt(a_cnt),
    .pop(pop), .pop_ch(pop_ch), .empty(a_empty),
    .dout(a_dout), .dout_vld(a_vld), .dout_ch(a_ch)
  );

  mcwmfifo #(.WIDTH(64), .DEPTH(12), .NCHAN(3), .HIWM(9), .LOWM(3)) u_b (
    .clk(clk), .reset(reset), .push(push), .push_ch(push_ch), .din(din),
    .full(b_full), .hiwm(b_hiwm), .ovf(b_ovf), .cnt(b_cnt),
    .pop(pop), .pop_ch(pop_ch), .empty(b_empty),
    .dout(b_dout), .dout_vld(b_vld), .dout_ch(b_ch)
  );

  // Reference model: one queue per channel per instance.
  int          dep [2] = '{16, 12};
  int          nch [2] = '{4, 3};
  int          hi  [2] = '{12, 9};
  int          lo  [2] = '{4, 3};
  logic [63:0] mq [2][4][$];
  logic        e_hiwm [2][4];
  logic        e_vld [2];
  logic [1:0]  e_ch  [2];
  logic [63:0] e_dout[2];
  logic        e_ovf [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int c = 0; c < 4; c++) begin
          mq[k][c].delete();
          e_hiwm[k][c] = 1'b0;
        end
        e_vld[k] = 1'b0;
        e_ch[k]  = 2'd0;
        e_ovf[k] = 1'b0;
      end else begin
        logic ap, pp;
        ap = push && (int'(push_ch) < nch[k]) && (mq[k][push_ch].size() < dep[k]);
        pp = pop  && (int'(pop_ch)  < nch[k]) && (mq[k][pop_ch].size() > 0);
        e_ovf[k] = push && !ap;
        e_vld[k] = pp;
        if (pp) begin
          e_dout[k] = mq[k][pop_ch].pop_front();
          e_ch[k]   = pop_ch;
        end
        if (ap) mq[k][push_ch].push_back(din);
        for (int c = 0; c < nch[k]; c++) begin
          if (mq[k][c].size() >= hi[k])      e_hiwm[k][c] = 1'b1;
          else if (mq[k][c].size() <= lo[k]) e_hiwm[k][c] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] xe, xf, xh;
    for (int k = 0; k < 2; k++) begin
      xe = '0; xf = '0; xh = '0;
      for (int c = 0; c < nch[k]; c++) begin
        xe[c] = (mq[k][c].size() == 0);
        xf[c] = (mq[k][c].size() == dep[k]);
        xh[c] = e_hiwm[k][c];
        if (k == 0) chk($sformatf("A.cnt%0d", c), 64'(a_cnt[c*5 +: 5]), 64'(mq[0][c].size()));
        else        chk($sformatf("B.cnt%0d", c), 64'(b_cnt[c*5 +: 5]), 64'(mq[1][c].size()));
      end
      if (k == 0) begin
        chk("A.empty", 64'(a_empty), 64'(xe));
        chk("A.full",  64'(a_full),  64'(xf));
        chk("A.hiwm",  64'(a_hiwm),  64'(xh));
        chk("A.ovf",   64'(a_ovf),   64'(e_ovf[0]));
        chk("A.vld",   64'(a_vld),   64'(e_vld[0]));
        chk("A.ch",    64'(a_ch),    64'(e_ch[0]));
        if (e_vld[0]) chk("A.dout", a_dout, e_dout[0]);
      end else begin
        chk("B.empty", 64'(b_empty), 64'(xe[2:0]));
        chk("B.full",  64'(b_full),  64'(xf[2:0]));
        chk("B.hiwm",  64'(b_hiwm),  64'(xh[2:0]));
        chk("B.ovf",   64'(b_ovf),   64'(e_ovf[1]));
        chk("B.vld",   64'(b_vld),   64'(e_vld[1]));
        chk("B.ch",    64'(b_ch),    64'(e_ch[1]));
        if (e_vld[1]) chk("B.dout", b_dout, e_dout[1]);
      end
    end
  endtask

  task automatic step(input logic ps, input int pc, input logic [63:0] d,
                      input logic pp, input int qc, input logic rs);
    logic [31:0] pcv, qcv;
    pcv = pc; qcv = qc;
    reset = rs; push = ps; push_ch = pcv[1:0]; din = d; pop = pp; pop_ch = qcv[1:0];
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    reset = 1'b1; push = 1'b0; push_ch = '0; din = '0; pop = 1'b0; pop_ch = '0;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Single push then pop on ch2
    step(1, 2, 64'hA5, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0);

    // Fill ch1 past capacity, then drain
    for (int i = 0; i < 17; i++) step(1, 1, rnd64(), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 1, 0);

    // Wrap on ch0 at steady depth 5 with ch1 holding 3 neighbours
    for (int i = 0; i < 3; i++)  step(1, 1, rnd64(), 0, 0, 0);
    for (int i = 0; i < 5; i++)  step(1, 0, rnd64(), 0, 0, 0);
    for (int i = 0; i < 35; i++) step(1, 0, rnd64(), 1, 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++)  step(0, 0, 0, 1, 1, 0);

    // Hysteresis on ch2 and (for the 3-channel instance, invalid) ch3
    for (int i = 0; i < 12; i++) step(1, 2, rnd64(), 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 2, 0);
    for (int i = 0; i < 13; i++) step(1, 3, rnd64(), 0, 0, 0);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 1, 3, 0);

    // Simultaneous push/pop: non-empty, empty, and pop held on empty
    step(1, 0, rnd64(), 0, 0, 0);
    step(1, 0, rnd64(), 0, 0, 0);
    step(1, 0, rnd64(), 1, 0, 0);
    step(1, 1, rnd64(), 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 2, 0);

    // Reset mid-operation with a pop accepted during reset
    for (int i = 0; i < 7; i++) step(1, 0, rnd64(), 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 3, rnd64(), 0, 0, 0);
    step(1, 1, rnd64(), 1, 0, 1);
    step(1, 0, 64'h1234, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Random traffic, occasional reset
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)), rnd64(),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 99) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
